// File: rtl/rrat_commit.sv
`default_nettype none
// ============================================================================
//  Module   : rrat_commit
//  Purpose  : Retirement RAT and commit consumer at the ROB head. Accepts one
//             retiring instruction per cycle, updates the committed
//             arch->phys map and returns the displaced physical register to
//             the free list through a small valid/ready FIFO. The whole map
//             is exported for speculative-RAT recovery after a flush.
//  Ports    : clk, rst_n          clock / async active-low reset
//             commit_*_i          retiring entry (valid, rd, pd, we)
//             commit_ready_o      commit accepted when valid && ready
//             flush_i             branch recovery strobe (map is the source)
//             free_valid_o/pd_o   freed phys reg towards the free list
//             free_ready_i        free list accepts free_pd_o
//             rrat_map_o          flattened map, entry i at [i*PW +: PW]
//             retire_count_o      accepted commits, wraps modulo 2^32
//  Options  : RRAT_FREE_BYPASS_EN - when defined, a freed register is handed
//             straight to the free list in the accept cycle if the FIFO is
//             empty and free_ready_i is high.
//  Revision : 1.0 - initial release
// ============================================================================
module rrat_commit #(
  parameter int PHYS_REGS    = 64,
  parameter int ARCH_REGS    = 32,
  parameter int FREE_Q_DEPTH = 4,
  localparam int PW = $clog2(PHYS_REGS),
  localparam int RW = $clog2(ARCH_REGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    commit_valid_i,
  input  logic [RW-1:0]           commit_rd_i,
  input  logic [PW-1:0]           commit_pd_i,
  input  logic                    commit_we_i,
  output logic                    commit_ready_o,
  input  logic                    flush_i,
  output logic                    free_valid_o,
  output logic [PW-1:0]           free_pd_o,
  input  logic                    free_ready_i,
  output logic [ARCH_REGS*PW-1:0] rrat_map_o,
  output logic [31:0]             retire_count_o
);

  localparam int QW = $clog2(FREE_Q_DEPTH);

  // Committed map and freed-register FIFO state
  logic [PW-1:0] rrat_q [ARCH_REGS];
  logic [PW-1:0] rrat_d [ARCH_REGS];
  logic [PW-1:0] fifo_q [FREE_Q_DEPTH];
  logic [QW:0]   head_q, head_d;
  logic [QW:0]   tail_q, tail_d;
  logic [31:0]   count_q, count_d;

  logic          empty_w, full_w, acc_w, freeing_w, push_w, pop_w, bypass_w;
  logic [PW-1:0] old_pd_w;

  // The map is the recovery source whether or not a flush is in progress,
  // so the strobe itself does not steer any state here.
  logic          unused_flush;
  assign unused_flush = flush_i;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty_w  = (head_q == tail_q);
  assign full_w   = (head_q[QW-1:0] == tail_q[QW-1:0]) && (head_q[QW] != tail_q[QW]);

  assign old_pd_w  = rrat_q[commit_rd_i];
  assign acc_w     = commit_valid_i && commit_ready_o;
  // rd=0 and non-writing entries never received a fresh pd, so nothing frees.
  assign freeing_w = acc_w && commit_we_i && (commit_rd_i != '0);

`ifdef RRAT_FREE_BYPASS_EN
  assign bypass_w     = freeing_w && empty_w && free_ready_i;
  assign free_valid_o = !empty_w || bypass_w;
  assign free_pd_o    = !empty_w ? fifo_q[head_q[QW-1:0]] :
                        (bypass_w ? old_pd_w : '0);
`else
  assign bypass_w     = 1'b0;
  assign free_valid_o = !empty_w;
  assign free_pd_o    = !empty_w ? fifo_q[head_q[QW-1:0]] : '0;
`endif

  assign pop_w  = !empty_w && free_ready_i;
  assign push_w = freeing_w && !bypass_w;

  // A pop in the same cycle makes room, so a full FIFO can still accept.
  assign commit_ready_o = !full_w || (!empty_w && free_ready_i);

  always_comb begin
    rrat_d = rrat_q;
    if (freeing_w) begin
      rrat_d[commit_rd_i] = commit_pd_i;
    end
  end

  always_comb begin
    head_d  = head_q + (QW+1)'(pop_w);
    tail_d  = tail_q + (QW+1)'(push_w);
    count_d = count_q + 32'(acc_w);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rrat_q[i] <= PW'(i);
      end
      for (int j = 0; j < FREE_Q_DEPTH; j++) begin
        fifo_q[j] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      rrat_q  <= rrat_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      // When full with a concurrent pop, tail aliases head: the popped entry
      // is read combinationally this cycle before being overwritten.
      if (push_w) begin
        fifo_q[tail_q[QW-1:0]] <= old_pd_w;
      end
    end
  end

  generate
    for (genvar g = 0; g < ARCH_REGS; g++) begin : g_map
      assign rrat_map_o[g*PW +: PW] = rrat_q[g];
    end
  endgenerate

  assign retire_count_o = count_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(freeing_w && (commit_pd_i == old_pd_w)))
        else $error("rrat_commit: commit pd %0d already mapped to rd %0d", commit_pd_i, commit_rd_i);
      assert (!(push_w && full_w && !pop_w))
        else $error("rrat_commit: push into full free FIFO without pop");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rrat_commit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rrat_commit
//  Purpose  : Directed self-checking bench for rrat_commit (default build,
//             freed registers always go through the FIFO).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rrat_commit;

  localparam int PW = 6;
  localparam int RW = 5;
  localparam int AR = 32;

  logic           clk;
  logic           rst_n;
  logic           commit_valid;
  logic [RW-1:0]  commit_rd;
  logic [PW-1:0]  commit_pd;
  logic           commit_we;
  logic           commit_ready;
  logic           flush;
  logic           free_valid;
  logic [PW-1:0]  free_pd;
  logic           free_ready;
  logic [AR*PW-1:0] rrat_map;
  logic [31:0]    retire_count;

  int n_pass;
  int n_total;

  rrat_commit #(
    .PHYS_REGS   (64),
    .ARCH_REGS   (32),
    .FREE_Q_DEPTH(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .commit_valid_i(commit_valid),
    .commit_rd_i   (commit_rd),
    .commit_pd_i   (commit_pd),
    .commit_we_i   (commit_we),
    .commit_ready_o(commit_ready),
    .flush_i       (flush),
    .free_valid_o  (free_valid),
    .free_pd_o     (free_pd),
    .free_ready_i  (free_ready),
    .rrat_map_o    (rrat_map),
    .retire_count_o(retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] map_at(input int idx);
    return rrat_map[idx*PW +: PW];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance past the next active edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [RW-1:0] rd, input logic [PW-1:0] pd, input logic we);
    commit_valid = v;
    commit_rd    = rd;
    commit_pd    = pd;
    commit_we    = we;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    free_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    repeat (2) tick();

    // T1: reset state
    check("rst_map5",   32'(map_at(5)), 32'd5);
    check("rst_fvalid", 32'(free_valid), 32'd0);
    check("rst_fpd",    32'(free_pd), 32'd0);
    check("rst_count",  retire_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_ready", 32'(commit_ready), 32'd1);

    // T2: simple commit, map/FIFO visible the cycle after accept
    free_ready = 1'b1;
    drive(1'b1, 5'd5, 6'd40, 1'b1);
    #1;
    check("t2_precommit_map5", 32'(map_at(5)), 32'd5);
    check("t2_same_fvalid",    32'(free_valid), 32'd0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check("t2_map5",   32'(map_at(5)), 32'd40);
    check("t2_fvalid", 32'(free_valid), 32'd1);
    check("t2_fpd",    32'(free_pd), 32'd5);
    check("t2_count",  retire_count, 32'd1);
    tick();
    check("t2_drained", 32'(free_valid), 32'd0);

    // T3: rd=0 and we=0 retire without freeing
    drive(1'b1, 5'd0, 6'd33, 1'b1);
    tick();
    drive(1'b1, 5'd3, 6'd34, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check("t3_map0",   32'(map_at(0)), 32'd0);
    check("t3_map3",   32'(map_at(3)), 32'd3);
    check("t3_fvalid", 32'(free_valid), 32'd0);
    check("t3_count",  retire_count, 32'd3);

    // T4: backpressure fills the FIFO
    free_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 5'(k), 6'(31 + k), 1'b1);
      tick();
    end
    drive(1'b1, 5'd6, 6'd36, 1'b1);
    #1;
    check("t4_full_ready", 32'(commit_ready), 32'd0);
    check("t4_count4",     retire_count, 32'd7);
    check("t4_head",       32'(free_pd), 32'd1);
    tick();
    check("t4_held_count", retire_count, 32'd7);
    check("t4_held_map6",  32'(map_at(6)), 32'd6);
    free_ready = 1'b1;
    #1;
    check("t4_pop_ready", 32'(commit_ready), 32'd1);
    check("t4_pop1",      32'(free_pd), 32'd1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check("t4_count5", retire_count, 32'd8);
    check("t4_map6",   32'(map_at(6)), 32'd36);
    check("t4_pop2",   32'(free_pd), 32'd2);
    tick();
    check("t4_pop3",   32'(free_pd), 32'd3);
    tick();
    check("t4_pop4",   32'(free_pd), 32'd4);
    tick();
    check("t4_pop6",   32'(free_pd), 32'd6);
    check("t4_map1",   32'(map_at(1)), 32'd32);
    check("t4_map4",   32'(map_at(4)), 32'd35);
    tick();
    check("t4_empty",  32'(free_valid), 32'd0);

    // T5: same rd back-to-back
    drive(1'b1, 5'd7, 6'd40, 1'b1);
    tick();
    drive(1'b1, 5'd7, 6'd41, 1'b1);
    check("t5_free7",  32'(free_pd), 32'd7);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check("t5_free40", 32'(free_pd), 32'd40);
    check("t5_map7",   32'(map_at(7)), 32'd41);
    tick();
    check("t5_empty",  32'(free_valid), 32'd0);
    check("t5_count",  retire_count, 32'd10);

    // T6: flush with a concurrent accept; flush alone changes nothing
    flush = 1'b1;
    drive(1'b1, 5'd9, 6'd50, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    free_ready = 1'b0;
    check("t6_map9",   32'(map_at(9)), 32'd50);
    check("t6_count",  retire_count, 32'd11);
    check("t6_fpd",    32'(free_pd), 32'd9);
    tick();
    flush = 1'b0;
    check("t6_hold_fvalid", 32'(free_valid), 32'd1);
    check("t6_hold_fpd",    32'(free_pd), 32'd9);
    check("t6_hold_count",  retire_count, 32'd11);
    check("t6_hold_map9",   32'(map_at(9)), 32'd50);

    // Reset mid-run with a non-empty FIFO
    drive(1'b1, 5'd10, 6'd51, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check("mr_map10_pre", 32'(map_at(10)), 32'd51);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_map5",   32'(map_at(5)), 32'd5);
    check("mr_map10",  32'(map_at(10)), 32'd10);
    check("mr_fvalid", 32'(free_valid), 32'd0);
    check("mr_fpd",    32'(free_pd), 32'd0);
    check("mr_count",  retire_count, 32'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mr_ready",  32'(commit_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
